// File: rtl/ex_muldiv_sequencer.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// Owns HI/LO, services MTHI/MTLO and raises the pipeline stall
// while an operation is in flight.
module ex_muldiv_sequencer #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [1:0]        i_op,
   input  logic [DATA_W-1:0] i_operand_a,
   input  logic [DATA_W-1:0] i_operand_b,
   input  logic              i_hilo_read,
   input  logic              i_mthi,
   input  logic              i_mtlo,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_flush,
   output logic              o_stall,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
   // acc: upper product half (mult) or partial remainder (div)
   // sh:  multiplier shifting out (mult) or dividend out / quotient in (div)
   logic [DATA_W-1:0]   acc_q, acc_d, sh_q, sh_d, opnd_q, opnd_d;
   logic                is_div_q, is_div_d, neg_q, neg_d, sa_q, sa_d;
   logic                divz_q, divz_d, done_q, done_d;

   // Operand magnitudes at issue; unsigned ops pass straight through.
   logic                signed_op, a_neg, b_neg;
   logic [DATA_W-1:0]   a_mag, b_mag;
   assign signed_op = ~i_op[0];
   assign a_neg     = signed_op & i_operand_a[DATA_W-1];
   assign b_neg     = signed_op & i_operand_b[DATA_W-1];
   assign a_mag     = a_neg ? -i_operand_a : i_operand_a;
   assign b_mag     = b_neg ? -i_operand_b : i_operand_b;

   // Multiply step: conditional add of the multiplicand, then shift right.
   logic [DATA_W:0]     madd;
   assign madd = {1'b0, acc_q} + {1'b0, (sh_q[0] ? opnd_q : '0)};

   // Divide step: shift in next dividend bit (DATA_W+1 wide), restore on borrow.
   logic [DATA_W:0]     dshift;
   logic                dge;
   logic [DATA_W-1:0]   dsub;
   assign dshift = {acc_q, sh_q[DATA_W-1]};
   assign dge    = dshift >= {1'b0, opnd_q};
   assign dsub   = dshift[DATA_W-1:0] - opnd_q;

   // Sign fix-up applied in FINISH.
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quot_fix, rem_fix;
   assign prod_fix = neg_q ? -{acc_q, sh_q} : {acc_q, sh_q};
   assign quot_fix = neg_q ? -sh_q : sh_q;
   assign rem_fix  = sa_q ? -acc_q : acc_q;

   // Outputs: stall holds the issuing instr through RUN and releases in FINISH.
   assign o_stall = ((state_q == S_RUN) & (i_start | i_hilo_read | i_mthi | i_mtlo))
                  | ((state_q == S_IDLE) & i_start);
   assign o_busy  = (state_q != S_IDLE);
   assign o_done  = done_q;
   assign o_hi    = hi_q;
   assign o_lo    = lo_q;

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_d    = acc_q;
      sh_d     = sh_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      sa_d     = sa_q;
      divz_d   = divz_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_flush) begin
               state_d = S_IDLE;
            end else if (i_start) begin
               state_d  = S_RUN;
               cnt_d    = '0;
               acc_d    = '0;
               is_div_d = i_op[1];
               opnd_d   = i_op[1] ? b_mag : a_mag;
               sh_d     = i_op[1] ? a_mag : b_mag;
               neg_d    = a_neg ^ b_neg;
               sa_d     = a_neg;
               divz_d   = i_op[1] & (i_operand_b == '0);
            end else begin
               if (i_mthi) hi_d = i_wdata;
               if (i_mtlo) lo_d = i_wdata;
            end
         end
         S_RUN: begin
            if (i_flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               if (is_div_q) begin
                  acc_d = dge ? dsub : dshift[DATA_W-1:0];
                  sh_d  = {sh_q[DATA_W-2:0], dge};
               end else begin
                  acc_d = madd[DATA_W:1];
                  sh_d  = {madd[0], sh_q[DATA_W-1:1]};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W-1)) state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            if (!i_flush) begin
               done_d = 1'b1;
               if (!is_div_q) begin
                  {hi_d, lo_d} = prod_fix;
               end else if (divz_q) begin
                  // Remainder path already yields the raw dividend.
                  hi_d = rem_fix;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quot_fix;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         acc_q    <= '0;
         sh_q     <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         sa_q     <= 1'b0;
         divz_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         acc_q    <= acc_d;
         sh_q     <= sh_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         sa_q     <= sa_d;
         divz_q   <= divz_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Bench for ex_muldiv_sequencer: arithmetic reference model with a
// countdown-based timing view, per-cycle compare, directed literals.
module tb_ex_muldiv_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [1:0]  i_op = 2'd0;
   logic [31:0] i_operand_a = '0, i_operand_b = '0, i_wdata = '0;
   logic        i_hilo_read = 1'b0, i_mthi = 1'b0, i_mtlo = 1'b0, i_flush = 1'b0;
   logic        o_stall, o_busy, o_done;
   logic [31:0] o_hi, o_lo;

   int n_cmp = 0;
   int n_err = 0;
   int n_done = 0;
   bit chk_en = 1'b0;

   ex_muldiv_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
      .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
      .i_hilo_read(i_hilo_read), .i_mthi(i_mthi), .i_mtlo(i_mtlo),
      .i_wdata(i_wdata), .i_flush(i_flush), .o_stall(o_stall),
      .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference result {HI,LO} from plain arithmetic.
   function automatic logic [63:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'd0: r = sa * sb;
         2'd1: r = {32'd0, a} * {32'd0, b};
         default: begin
            if (b == 32'd0)      r = {a, 32'hFFFF_FFFF};
            else if (op == 2'd2) r = {32'(sa % sb), 32'(sa / sb)};
            else                 r = {a % b, a / b};
         end
      endcase
      return r;
   endfunction

   // Model: m_cnt = edges remaining until the result lands (0 = idle).
   int          m_cnt = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [63:0] m_res = '0;
   logic        m_done = 1'b0;

   always @(posedge i_clk) begin
      m_done <= 1'b0;
      if (!i_rst_n) begin
         m_cnt <= 0; m_hi <= '0; m_lo <= '0;
      end else if (m_cnt == 0) begin
         if (!i_flush) begin
            if (i_start) begin
               m_cnt <= 33;
               m_res <= model_res(i_op, i_operand_a, i_operand_b);
            end else begin
               if (i_mthi) m_hi <= i_wdata;
               if (i_mtlo) m_lo <= i_wdata;
            end
         end
      end else if (i_flush) begin
         m_cnt <= 0;
      end else begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; m_done <= 1'b1;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge i_clk) begin
      if (chk_en) begin
         logic exp_stall;
         exp_stall = ((m_cnt > 1) && (i_start || i_hilo_read || i_mthi || i_mtlo))
                   || ((m_cnt == 0) && i_start);
         chk("hi", o_hi, m_hi);
         chk("lo", o_lo, m_lo);
         chk("done", {31'd0, o_done}, {31'd0, m_done});
         chk("busy", {31'd0, o_busy}, {31'd0, m_cnt != 0});
         chk("stall", {31'd0, o_stall}, {31'd0, exp_stall});
      end
   end

   always @(negedge i_clk) if (o_done === 1'b1) n_done <= n_done + 1;

   task automatic step();
      @(posedge i_clk); #1;
   endtask

   // Hold the instruction in ID/EX until a cycle without stall.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rd, output int stalls);
      bit s, ok;
      i_start = 1'b1; i_op = op; i_operand_a = a; i_operand_b = b; i_hilo_read = rd;
      stalls = 0; ok = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge i_clk); s = o_stall;
         if (s) stalls++;
         step();
         i_operand_a = $urandom; i_operand_b = $urandom;
         if (!s) ok = 1'b1;
      end
      i_start = 1'b0; i_hilo_read = 1'b0;
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL issue_timeout: got stall held 60 cycles want release");
      end
   endtask

   initial begin
      int st, d0;
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, d0;
      step(); step();
      chk_en = 1'b1;
      chk("rst_hi", o_hi, 32'h0);
      chk("rst_lo", o_lo, 32'h0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_done", {31'd0, o_done}, 32'd0);
      i_rst_n = 1'b1;
      step();

      // MULTU max*max, one done pulse, 33 stalled cycles
      d0 = n_done;
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, st);
      chk("t1_done_now", {31'd0, o_done}, 32'd1);
      chk("t1_hi", o_hi, 32'hFFFF_FFFE);
      chk("t1_lo", o_lo, 32'h0000_0001);
      chk("t1_model_lo", m_lo, 32'h0000_0001);
      chk("t1_stalls", st, 32'd33);
      step(); step();
      chk("t1_pulses", n_done - d0, 32'd1);

      issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, st);
      chk("t2_mult_hi", o_hi, 32'hFFFF_FFFF);
      chk("t2_mult_lo", o_lo, 32'hFFFF_FFEB);
      // back-to-back: issued in the first IDLE cycle
      issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, st);
      chk("t2_div_lo", o_lo, 32'hFFFF_FFFD);
      chk("t2_div_hi", o_hi, 32'hFFFF_FFFF);
      chk("t2_model_hi", m_hi, 32'hFFFF_FFFF);

      issue(2'd3, 32'd100, 32'd0, 1'b0, st);
      chk("t3_divz_lo", o_lo, 32'hFFFF_FFFF);
      chk("t3_divz_hi", o_hi, 32'd100);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, st);
      chk("t3_ovf_lo", o_lo, 32'h8000_0000);
      chk("t3_ovf_hi", o_hi, 32'h0);
      issue(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, st);
      chk("t3_sdivz_lo", o_lo, 32'hFFFF_FFFF);
      chk("t3_sdivz_hi", o_hi, 32'hFFFF_FFF0);
      issue(2'd3, 32'hFFFF_FFFF, 32'd10, 1'b0, st);
      chk("divu_lo", o_lo, 32'h1999_9999);
      chk("divu_hi", o_hi, 32'd5);
      issue(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, st);
      chk("div_neg_b_lo", o_lo, 32'hFFFF_FFFD);
      chk("div_neg_b_hi", o_hi, 32'd1);

      // MTLO in IDLE keeps HI
      i_mtlo = 1'b1; i_wdata = 32'hDEAD_BEEF; step(); i_mtlo = 1'b0;
      chk("t4_mtlo_lo", o_lo, 32'hDEAD_BEEF);
      chk("t4_mtlo_hi", o_hi, 32'd1);
      // start beats a simultaneous MTHI
      i_mthi = 1'b1; i_wdata = 32'h1234_5678;
      issue(2'd1, 32'd3, 32'd5, 1'b0, st);
      i_mthi = 1'b0;
      chk("start_wins_hi", o_hi, 32'h0);
      chk("start_wins_lo", o_lo, 32'd15);
      // MFHI held through RUN: stall until FINISH
      issue(2'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, st);
      chk("t4_rd_stalls", st, 32'd33);
      chk("t4_rd_hi", o_hi, 32'hFFFF_FFFF);
      chk("t4_rd_lo", o_lo, 32'h8000_0001);

      // flush in IDLE blocks both start and MT write
      i_start = 1'b1; i_flush = 1'b1; i_mtlo = 1'b1; i_wdata = 32'h5555_5555; step();
      i_start = 1'b0; i_flush = 1'b0; i_mtlo = 1'b0;
      chk("idle_flush_busy", {31'd0, o_busy}, 32'd0);
      chk("idle_flush_lo", o_lo, 32'h8000_0001);

      // flush at RUN cycle 10
      d0 = n_done;
      i_start = 1'b1; i_op = 2'd1; i_operand_a = 32'd2; i_operand_b = 32'd2;
      step();
      repeat (9) step();
      i_flush = 1'b1; i_start = 1'b0; step(); i_flush = 1'b0;
      chk("t5_busy", {31'd0, o_busy}, 32'd0);
      chk("t5_stall", {31'd0, o_stall}, 32'd0);
      repeat (30) step();
      chk("t5_hi", o_hi, 32'hFFFF_FFFF);
      chk("t5_lo", o_lo, 32'h8000_0001);
      chk("t5_no_done", n_done - d0, 32'd0);

      // reset mid-RUN, then a fresh MULT
      i_start = 1'b1; i_op = 2'd3; i_operand_a = 32'd1000; i_operand_b = 32'd7;
      step(); repeat (5) step();
      i_rst_n = 1'b0; i_start = 1'b0; step(); i_rst_n = 1'b1;
      chk("t6_hi", o_hi, 32'h0);
      chk("t6_lo", o_lo, 32'h0);
      chk("t6_busy", {31'd0, o_busy}, 32'd0);
      chk("t6_stall", {31'd0, o_stall}, 32'd0);
      issue(2'd0, 32'd6, 32'd7, 1'b0, st);
      chk("t6_lo42", o_lo, 32'd42);
      chk("t6_hi0", o_hi, 32'd0);
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
